ea_sequencer: RTL and testbench

Operand-address stage directly downstream of the instruction decoder. It takes the latched IR, the latched PC and the decoder's addressing flags (DIR, IND, PPIND, MP) and produces the 12-bit effective address (EA) for memory-reference instructions. It runs the extra memory cycles for indirect pointer fetch and for auto-index increment/write-back (locations 0010-0017 on page zero). The execute sequencer consumes EA and EA_VALID.

---
 rtl/ea_sequencer.sv | 152 +++++++++++++++
 tb/tb_ea_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ea_sequencer.sv
// ea_sequencer: operand-address stage behind the instruction decoder.
// Builds the 12-bit effective address for memory-reference instructions.
// For indirect references it runs one pointer read. For auto-index
// references (0010-0017 on page zero, AUTOINDEX=1) it also runs one
// increment write-back.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle request, sampled only in IDLE
//   ir, pclatched         latched instruction and its fetch address
//   dir, ind, ppind, mp   decoder addressing flags (priority ppind > ind > dir)
//   mem_addr/rd/wr/wdata  memory request side
//   mem_rdata, mem_ack    memory response side
//   ea, ea_valid          effective address and its one-cycle "final" pulse
//   noaddr                one-cycle pulse for a start with no addressing flag
//   busy                  high in every state except IDLE
//   state_dbg             current FSM state, for checkers
//
// Memory handshake: a request (mem_rd or mem_wr) is raised with a stable
// mem_addr/mem_wdata. It is held until the cycle in which mem_ack is
// sampled high. It drops in the following cycle. Read data is taken in
// the mem_ack cycle. mem_ack is ignored while no request is outstanding.
// mem_rd and mem_wr are never high together.
module ea_sequencer #(
  parameter bit AUTOINDEX = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] ir,
  input  logic [11:0] pclatched,
  input  logic        dir,
  input  logic        ind,
  input  logic        ppind,
  input  logic        mp,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  input  logic        mem_ack,
  output logic [11:0] ea,
  output logic        ea_valid,
  output logic        noaddr,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_NONE = 3'd4
  } state_t;

  state_t      state;
  logic [11:0] ptr;
  logic        autoinc;
  logic [11:0] pa_next;
  logic [11:0] ptr_inc;
  logic        unused_bits;

  // Page address: page bits come from the fetch address for current-page
  // references and are forced to zero for page-zero references.
  assign pa_next     = {mp ? pclatched[11:7] : 5'b0, ir[6:0]};
  // The increment wraps naturally: 7777 + 1 = 0000 with no carry out.
  assign ptr_inc     = ptr + 12'd1;
  assign state_dbg   = state;
  assign unused_bits = ^{ir[11:7], pclatched[6:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ptr       <= 12'd0;
      autoinc   <= 1'b0;
      mem_addr  <= 12'd0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 12'd0;
      ea        <= 12'd0;
      ea_valid  <= 1'b0;
      noaddr    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            autoinc <= 1'b0;
            if (ppind || ind) begin
              // The page address is held in mem_addr for both the read and
              // any write-back, so later changes to ir/pclatched are harmless.
              state    <= S_RD;
              mem_rd   <= 1'b1;
              mem_addr <= pa_next;
              autoinc  <= ppind && AUTOINDEX;
            end else if (dir) begin
              state    <= S_DONE;
              ea       <= pa_next;
              ea_valid <= 1'b1;
            end else begin
              state  <= S_NONE;
              noaddr <= 1'b1;
            end
          end
        end

        S_RD: begin
          if (mem_ack) begin
            ptr    <= mem_rdata;
            mem_rd <= 1'b0;
            if (autoinc) begin
              state     <= S_WR;
              mem_wr    <= 1'b1;
              mem_wdata <= mem_rdata + 12'd1;
            end else begin
              state    <= S_DONE;
              ea       <= mem_rdata;
              ea_valid <= 1'b1;
            end
          end
        end

        S_WR: begin
          if (mem_ack) begin
            state    <= S_DONE;
            mem_wr   <= 1'b0;
            ea       <= ptr_inc;
            ea_valid <= 1'b1;
          end
        end

        // Pulse cycles. A start seen here is dropped, not queued.
        S_DONE, S_NONE: begin
          state    <= S_IDLE;
          ea_valid <= 1'b0;
          noaddr   <= 1'b0;
          busy     <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ea_sequencer.sv
// tb_ea_sequencer: checks ea_sequencer against an address model.
// Two instances are used: u_auto (AUTOINDEX=1) and u_plain (AUTOINDEX=0).
// Each operation runs against one of them, chosen by sel. A bench-side
// memory array answers the requests with a chosen number of wait cycles.
module tb_ea_sequencer;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // shared stimulus
  logic        start, sel;
  logic [11:0] ir, pclatched, mem_rdata;
  logic        dir, ind, ppind, mp, mem_ack;

  // per-instance wiring
  logic        start_a, start_b, ack_a, ack_b;
  logic [11:0] addr_a, addr_b, wdata_a, wdata_b, ea_a, ea_b;
  logic        rd_a, rd_b, wr_a, wr_b, ev_a, ev_b, na_a, na_b, busy_a, busy_b;
  logic [2:0]  st_a, st_b;

  assign start_a = start & sel;
  assign start_b = start & ~sel;
  assign ack_a   = mem_ack & sel;
  assign ack_b   = mem_ack & ~sel;

  // observed view of the selected instance
  logic [11:0] o_addr, o_wdata, o_ea;
  logic        o_rd, o_wr, o_ev, o_na, o_busy;
  assign o_addr  = sel ? addr_a  : addr_b;
  assign o_wdata = sel ? wdata_a : wdata_b;
  assign o_ea    = sel ? ea_a    : ea_b;
  assign o_rd    = sel ? rd_a    : rd_b;
  assign o_wr    = sel ? wr_a    : wr_b;
  assign o_ev    = sel ? ev_a    : ev_b;
  assign o_na    = sel ? na_a    : na_b;
  assign o_busy  = sel ? busy_a  : busy_b;

  ea_sequencer #(.AUTOINDEX(1'b1)) u_auto (
    .clk(clk), .reset_n(reset_n), .start(start_a), .ir(ir), .pclatched(pclatched),
    .dir(dir), .ind(ind), .ppind(ppind), .mp(mp),
    .mem_addr(addr_a), .mem_rd(rd_a), .mem_wr(wr_a), .mem_wdata(wdata_a),
    .mem_rdata(mem_rdata), .mem_ack(ack_a),
    .ea(ea_a), .ea_valid(ev_a), .noaddr(na_a), .busy(busy_a), .state_dbg(st_a)
  );

  ea_sequencer #(.AUTOINDEX(1'b0)) u_plain (
    .clk(clk), .reset_n(reset_n), .start(start_b), .ir(ir), .pclatched(pclatched),
    .dir(dir), .ind(ind), .ppind(ppind), .mp(mp),
    .mem_addr(addr_b), .mem_rd(rd_b), .mem_wr(wr_b), .mem_wdata(wdata_b),
    .mem_rdata(mem_rdata), .mem_ack(ack_b),
    .ea(ea_b), .ea_valid(ev_b), .noaddr(na_b), .busy(busy_b), .state_dbg(st_b)
  );

  // scoreboard
  logic [11:0] exp_q[$];
  logic [11:0] mem [4096];
  logic [11:0] ea_model [2];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0o expected %0o (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    start = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ea", o_ea, 12'o0);
    check("rst_addr", o_addr, 12'o0);
    check("rst_wdata", o_wdata, 12'o0);
    check("rst_ctl", {7'd0, o_rd, o_wr, o_ev, o_na, o_busy}, 12'o0);
    reset_n = 1'b1;
    ea_model[0] = 12'o0;
    ea_model[1] = 12'o0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // driver + reference model for one operation.
  // flg = {dir, ind, ppind, mp}; k_rd/k_wr = request cycle in which ack arrives.
  task automatic run_op(input logic [11:0] i_ir, input logic [11:0] i_pc,
                        input logic [3:0] flg, input int k_rd, input int k_wr,
                        input bit noise);
    logic [11:0] pa, ptr, exp_ea;
    int kind; // 0 direct, 1 indirect, 2 autoindex, 3 none
    int lat, rd_cnt, wr_cnt, exp_rd, exp_wr;
    bit finished;
    int idx;
    idx = sel ? 1 : 0;
    pa  = (flg[0] ? (i_pc & 12'o7600) : 12'o0) | (i_ir & 12'o0177);
    ptr = mem[pa];
    if (flg[1])      kind = sel ? 2 : 1;
    else if (flg[2]) kind = 1;
    else if (flg[3]) kind = 0;
    else             kind = 3;
    case (kind)
      0: begin exp_ea = pa;                         lat = 1;               exp_rd = 0;    exp_wr = 0;    end
      1: begin exp_ea = ptr;                        lat = k_rd + 1;        exp_rd = k_rd; exp_wr = 0;    end
      2: begin exp_ea = 12'((ptr + 1) % 4096);      lat = k_rd + k_wr + 1; exp_rd = k_rd; exp_wr = k_wr; end
      default: begin exp_ea = ea_model[idx];        lat = 1;               exp_rd = 0;    exp_wr = 0;    end
    endcase
    exp_q.push_back(exp_ea);

    ir = i_ir; pclatched = i_pc;
    {dir, ind, ppind, mp} = flg;
    start = 1'b1; mem_ack = 1'b0;
    rd_cnt = 0; wr_cnt = 0; finished = 0;
    for (int c = 1; c <= 40 && !finished; c++) begin
      @(negedge clk);
      check("busy", {11'd0, o_busy}, 12'd1);
      check("rd_wr_excl", {11'd0, o_rd & o_wr}, 12'd0);
      mem_ack = 1'b0;
      mem_rdata = 12'($urandom);
      if (o_rd) begin
        rd_cnt++;
        check("rd_addr", o_addr, pa);
        if (rd_cnt == k_rd) begin mem_ack = 1'b1; mem_rdata = mem[o_addr]; end
      end else if (o_wr) begin
        wr_cnt++;
        check("wr_addr", o_addr, pa);
        check("wr_data", o_wdata, exp_ea);
        if (wr_cnt == k_wr) begin mem_ack = 1'b1; mem[o_addr] = o_wdata; end
      end else if (noise) begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (o_ev || o_na) begin
        finished = 1;
        check("latency", 12'(c), 12'(lat));
        check("noaddr", {11'd0, o_na}, {11'd0, kind == 3});
        check("ea_valid", {11'd0, o_ev}, {11'd0, kind != 3});
        check("ea", o_ea, exp_q.pop_front());
      end
      // inputs are free to move once start has been taken
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ir = 12'($urandom); pclatched = 12'($urandom);
    end
    if (!finished) begin
      check("timeout", 12'd1, 12'd0);
      void'(exp_q.pop_front());
    end
    check("rd_cycles", 12'(rd_cnt), 12'(exp_rd));
    check("wr_cycles", 12'(wr_cnt), 12'(exp_wr));
    ea_model[idx] = exp_ea;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      mem_ack = 1'b0;
      check("idle_ctl", {8'd0, o_rd, o_wr, o_ev, o_na, o_busy}, 12'd0);
      check("ea_hold", o_ea, ea_model[idx]);
    end
  endtask

  task automatic reset_mid_write();
    bit seen;
    seen = 0;
    sel = 1'b1;
    mem[12'o0010] = 12'o3777;
    ir = 12'o1410; pclatched = 12'o4620;
    {dir, ind, ppind, mp} = 4'b0010;
    start = 1'b1; mem_ack = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      mem_ack = 1'b0;
      if (o_wr) seen = 1;
      else if (o_rd) begin mem_ack = 1'b1; mem_rdata = mem[o_addr]; end
    end
    check("mid_wr_reached", {11'd0, seen}, 12'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_wr_rst_wr", {11'd0, o_wr}, 12'd0);
    check("mid_wr_rst_busy", {11'd0, o_busy}, 12'd0);
    check("mid_wr_rst_ea", o_ea, 12'o0);
    check("mid_wr_no_writeback", mem[12'o0010], 12'o3777);
    @(negedge clk);
    reset_n = 1'b1;
    ea_model[0] = 12'o0;
    ea_model[1] = 12'o0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; sel = 1'b1; mem_ack = 1'b0; mem_rdata = 12'o0;
    ir = 12'o0; pclatched = 12'o0; {dir, ind, ppind, mp} = 4'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    #12;
    apply_reset();

    // directed cases
    sel = 1'b1;
    run_op(12'o1323, 12'o4620, 4'b1001, 1, 1, 0);   // direct, current page -> 4723
    run_op(12'o1123, 12'o4620, 4'b1000, 1, 1, 0);   // direct, page zero -> 0123
    mem[12'o4723] = 12'o2345;
    run_op(12'o1323, 12'o4620, 4'b0101, 3, 1, 0);   // indirect, 3-cycle wait -> 2345
    mem[12'o0010] = 12'o3777;
    run_op(12'o1410, 12'o4620, 4'b0010, 1, 1, 0);   // autoindex -> 4000
    check("autoinc_mem", mem[12'o0010], 12'o4000);
    mem[12'o0010] = 12'o7777;
    run_op(12'o1410, 12'o4620, 4'b0010, 1, 1, 0);   // autoindex wrap -> 0000
    check("autoinc_wrap_mem", mem[12'o0010], 12'o0000);
    run_op(12'o7200, 12'o4620, 4'b0000, 1, 1, 1);   // no flags -> noaddr, ea unchanged
    sel = 1'b0;
    mem[12'o0010] = 12'o3777;
    run_op(12'o1410, 12'o4620, 4'b0010, 1, 1, 0);   // AUTOINDEX=0 -> 3777, no write
    check("plain_mem", mem[12'o0010], 12'o3777);
    sel = 1'b1;
    run_op(12'o1410, 12'o0000, 4'b1110, 2, 3, 1);   // all flags: ppind wins

    reset_mid_write();
    run_op(12'o1323, 12'o4620, 4'b1001, 1, 1, 0);

    // randomized traffic on both instances
    for (int n = 0; n < 200; n++) begin
      sel = 1'($urandom_range(0, 1));
      run_op(12'($urandom), 12'($urandom), 4'($urandom_range(0, 15)),
             $urandom_range(1, 4), $urandom_range(1, 4), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
